pipe_stage_reg: RTL and testbench

Parametrised pipeline-stage register, the generalised successor to the fixed EX/MEM latch. It carries a control bundle, a data bundle and a valid bit through DEPTH cascaded stages. It supports per-stage flush, a stall mode selectable between bubble-insert and hold, and optional bubble/flush performance counters. The block is instantiated between any two core pipeline stages (ID/EX, EX/MEM, MEM/WB) in place of hand-written latches.

---
 rtl/pipe_reg_pkg.sv | 44 ++++
 rtl/pipe_stage_reg_slice.sv | 53 +++++
 rtl/pipe_stage_reg.sv | 117 +++++++++++
 tb/tb_pipe_stage_reg.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_pkg.sv
// Shared constants and control-bundle layouts for pipe_stage_reg instantiation sites.
// Stall-mode encodings, the depth limit and named ctrl structs live here.
package pipe_reg_pkg;

  localparam int STALL_BUBBLE = 0;
  localparam int STALL_HOLD   = 1;
  localparam int DEPTH_MAX    = 4;

  // ID/EX control bundle (16 bits)
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic [2:0] mem_size;
    logic [1:0] wb_sel;
  } id_ex_ctrl_t;

  // EX/MEM control bundle (16 bits)
  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic [2:0] mem_size;
    logic       mem_sext;
    logic [1:0] wb_sel;
    logic [4:0] rsvd;
  } ex_mem_ctrl_t;

  // MEM/WB control bundle (16 bits)
  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic [1:0]  wb_sel;
    logic [11:0] rsvd;
  } mem_wb_ctrl_t;

endpackage

// File: rtl/pipe_stage_reg_slice.sv
// One pipeline stage: valid/ctrl/data flops with kill and hold handling.
// A kill while holding keeps the stage's own data; otherwise data always follows the source.
module pipe_reg_slice
  import pipe_reg_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_valid,
  input  logic [CTRL_W-1:0] src_ctrl,
  input  logic [DATA_W-1:0] src_data,
  input  logic              kill,
  input  logic              hold,
  output logic              valid_q,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic [DATA_W-1:0] data_q
);

  logic              valid_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic [DATA_W-1:0] data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (kill) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = hold ? data_q : src_data;
    end else if (!hold) begin
      // an invalid entry never carries live control
      valid_d = src_valid;
      ctrl_d  = src_valid ? src_ctrl : '0;
      data_d  = src_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// DEPTH-stage pipeline register with per-stage flush and bubble/hold stall modes.
// Define PIPE_REG_PERF_EN to build the saturating bubble/flush counters; otherwise they read 0.
module pipe_stage_reg
  import pipe_reg_pkg::*;
#(
  parameter int DATA_W     = 96,
  parameter int CTRL_W     = 16,
  parameter int DEPTH      = 1,
  parameter int STALL_MODE = STALL_BUBBLE,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic [DEPTH-1:0]  flush,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic HOLD_MODE = (STALL_MODE == STALL_HOLD);

  logic [DEPTH-1:0]  stg_valid;
  logic [CTRL_W-1:0] stg_ctrl [DEPTH];
  logic [DATA_W-1:0] stg_data [DEPTH];
  logic              hold_all;
`ifdef PIPE_REG_PERF_EN
  logic [DEPTH-1:0]  src_valid_vec;
`endif

  assign hold_all = HOLD_MODE && stall;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic              s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
    logic              s_kill;

    if (gi == 0) begin : g_head
      // bubble mode turns a stall into a kill of the entering entry only
      assign s_valid = in_valid;
      assign s_ctrl  = in_ctrl;
      assign s_data  = in_data;
      assign s_kill  = flush[0] | (stall & ~HOLD_MODE);
    end else begin : g_chain
      assign s_valid = stg_valid[gi-1];
      assign s_ctrl  = stg_ctrl[gi-1];
      assign s_data  = stg_data[gi-1];
      assign s_kill  = flush[gi];
    end

`ifdef PIPE_REG_PERF_EN
    assign src_valid_vec[gi] = s_valid;
`endif

    pipe_reg_slice #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_slice (
      .clk       (clk),
      .rst       (rst),
      .src_valid (s_valid),
      .src_ctrl  (s_ctrl),
      .src_data  (s_data),
      .kill      (s_kill),
      .hold      (hold_all),
      .valid_q   (stg_valid[gi]),
      .ctrl_q    (stg_ctrl[gi]),
      .data_q    (stg_data[gi])
    );
  end

  assign out_valid = stg_valid[DEPTH-1];
  assign out_ctrl  = stg_ctrl[DEPTH-1];
  assign out_data  = stg_data[DEPTH-1];

`ifdef PIPE_REG_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             bubble_evt, flush_evt;

  assign bubble_evt = stall && !flush[0] && !HOLD_MODE && in_valid;
  assign flush_evt  = |(flush & src_valid_vec);

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (bubble_evt && (bubble_cnt_q != CNT_MAX)) bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    if (flush_evt && (flush_cnt_q != CNT_MAX))   flush_cnt_d  = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`else
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: four instances (depth/mode variants) share one stimulus bus.
// Counter expectations follow PIPE_REG_PERF_EN (zero when the macro is undefined).
module tb_pipe_stage_reg;

`ifdef PIPE_REG_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_ctrl = '0;
  logic [95:0] in_data = '0;
  logic        stall = 1'b0;
  logic [3:0]  flush_v = '0;

  int checks = 0;
  int failures = 0;

  logic        d3_ov, b1_ov, h2_ov, f2_ov;
  logic [15:0] d3_oc, b1_oc, h2_oc, f2_oc;
  logic [95:0] d3_od, b1_od, h2_od, f2_od;
  logic [15:0] d3_bc, d3_fc, h2_bc, h2_fc, f2_bc, f2_fc;
  logic [3:0]  b1_bc, b1_fc;

  pipe_stage_reg #(.DATA_W(96), .CTRL_W(16), .DEPTH(3), .STALL_MODE(0), .CNT_W(16)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
    .stall(stall), .flush(flush_v[2:0]), .out_valid(d3_ov), .out_ctrl(d3_oc),
    .out_data(d3_od), .bubble_cnt(d3_bc), .flush_cnt(d3_fc));

  pipe_stage_reg #(.DATA_W(96), .CTRL_W(16), .DEPTH(1), .STALL_MODE(0), .CNT_W(4)) u_b1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
    .stall(stall), .flush(flush_v[0:0]), .out_valid(b1_ov), .out_ctrl(b1_oc),
    .out_data(b1_od), .bubble_cnt(b1_bc), .flush_cnt(b1_fc));

  pipe_stage_reg #(.DATA_W(96), .CTRL_W(16), .DEPTH(2), .STALL_MODE(1), .CNT_W(16)) u_h2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
    .stall(stall), .flush(flush_v[1:0]), .out_valid(h2_ov), .out_ctrl(h2_oc),
    .out_data(h2_od), .bubble_cnt(h2_bc), .flush_cnt(h2_fc));

  pipe_stage_reg #(.DATA_W(96), .CTRL_W(16), .DEPTH(2), .STALL_MODE(0), .CNT_W(16)) u_f2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
    .stall(stall), .flush(flush_v[1:0]), .out_valid(f2_ov), .out_ctrl(f2_oc),
    .out_data(f2_od), .bubble_cnt(f2_bc), .flush_cnt(f2_fc));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] c, input logic [95:0] d,
                       input logic s, input logic [3:0] f);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
    stall    = s;
    flush_v  = f;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 16'h0, 96'h0, 1'b0, 4'h0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [112:0] exp_o;
    logic [111:0] cnts;
    drive(1'b1, 16'hFFFF, 96'h5A, 1'b0, 4'h0);
    repeat (3) tick();
    exp_o = {1'b1, 16'hFFFF, 96'h5A};
    checks++;
    if ({d3_ov, d3_oc, d3_od} !== exp_o) begin
      failures++;
      $display("FAIL reset_preload got=%h exp=%h", {d3_ov, d3_oc, d3_od}, exp_o);
    end
    rst = 1'b1;
    drive(1'b1, 16'hFFFF, 96'h5A, 1'b1, 4'hF);
    tick();
    $display("reset: d3=%h b1=%h h2=%h f2=%h", {d3_ov, d3_oc, d3_od}, {b1_ov, b1_oc, b1_od},
             {h2_ov, h2_oc, h2_od}, {f2_ov, f2_oc, f2_od});
    checks++;
    if ({d3_ov, d3_oc, d3_od} !== 113'h0) begin
      failures++;
      $display("FAIL reset_d3 got=%h exp=0", {d3_ov, d3_oc, d3_od});
    end
    checks++;
    if ({b1_ov, b1_oc, b1_od} !== 113'h0) begin
      failures++;
      $display("FAIL reset_b1 got=%h exp=0", {b1_ov, b1_oc, b1_od});
    end
    checks++;
    if ({h2_ov, h2_oc, h2_od, f2_ov, f2_oc, f2_od} !== 226'h0) begin
      failures++;
      $display("FAIL reset_h2_f2 got=%h exp=0", {h2_ov, h2_oc, h2_od, f2_ov, f2_oc, f2_od});
    end
    cnts = {d3_bc, d3_fc, b1_bc, b1_fc, h2_bc, h2_fc, f2_bc, f2_fc};
    checks++;
    if (cnts !== 112'h0) begin
      failures++;
      $display("FAIL reset_counters got=%h exp=0", cnts);
    end
    rst = 1'b0;
    drive(1'b0, 16'h0, 96'h0, 1'b0, 4'h0);
  endtask

  task automatic test_latency();
    logic exp_v;
    do_reset();
    drive(1'b1, 16'h0011, 96'h1234, 1'b0, 4'h0);
    tick();
    drive(1'b0, 16'h0, 96'h0, 1'b0, 4'h0);
    for (int c = 1; c <= 4; c++) begin
      exp_v = (c == 3);
      $display("latency: edge=%0d out_valid=%0b ctrl=%h data=%h", c, d3_ov, d3_oc, d3_od);
      checks++;
      if (d3_ov !== exp_v) begin
        failures++;
        $display("FAIL latency_valid edge=%0d got=%0b exp=%0b", c, d3_ov, exp_v);
      end
      if (c == 3) begin
        checks++;
        if ({d3_oc, d3_od} !== {16'h0011, 96'h1234}) begin
          failures++;
          $display("FAIL latency_payload got=%h/%h exp=0011/1234", d3_oc, d3_od);
        end
      end
      if (c < 4) tick();
    end
  endtask

  task automatic test_bubble();
    logic [3:0] exp_bc, exp_fc;
    do_reset();
    drive(1'b1, 16'h0007, 96'hABCD, 1'b1, 4'h0);
    tick();
    exp_bc = PERF ? 4'd1 : 4'd0;
    $display("bubble: out=%h bubble_cnt=%0d flush_cnt=%0d", {b1_ov, b1_oc, b1_od}, b1_bc, b1_fc);
    checks++;
    if ({b1_ov, b1_oc, b1_od} !== {1'b0, 16'h0, 96'hABCD}) begin
      failures++;
      $display("FAIL bubble_out got=%h exp=%h", {b1_ov, b1_oc, b1_od}, {1'b0, 16'h0, 96'hABCD});
    end
    checks++;
    if ({b1_bc, b1_fc} !== {exp_bc, 4'd0}) begin
      failures++;
      $display("FAIL bubble_cnt got=%0d/%0d exp=%0d/0", b1_bc, b1_fc, exp_bc);
    end
    drive(1'b1, 16'h0007, 96'hABCD, 1'b0, 4'h0);
    tick();
    checks++;
    if ({b1_ov, b1_oc, b1_od, b1_bc} !== {1'b1, 16'h0007, 96'hABCD, exp_bc}) begin
      failures++;
      $display("FAIL bubble_release got=%h cnt=%0d exp valid ctrl 0007 cnt=%0d",
               {b1_ov, b1_oc, b1_od}, b1_bc, exp_bc);
    end
    drive(1'b0, 16'h00FF, 96'h77, 1'b0, 4'h0);
    tick();
    checks++;
    if ({b1_ov, b1_oc, b1_od} !== {1'b0, 16'h0, 96'h77}) begin
      failures++;
      $display("FAIL invalid_ctrl_zero got=%h exp=%h", {b1_ov, b1_oc, b1_od}, {1'b0, 16'h0, 96'h77});
    end
    // flush[0] with stall: flush wins, so the bubble counter must not move
    drive(1'b1, 16'h0007, 96'hABCD, 1'b1, 4'h1);
    tick();
    exp_fc = PERF ? 4'd1 : 4'd0;
    $display("bubble+flush: out=%h bubble_cnt=%0d flush_cnt=%0d", {b1_ov, b1_oc, b1_od}, b1_bc, b1_fc);
    checks++;
    if ({b1_ov, b1_oc, b1_od, b1_bc, b1_fc} !== {1'b0, 16'h0, 96'hABCD, exp_bc, exp_fc}) begin
      failures++;
      $display("FAIL flush0_over_stall got=%h cnt=%0d/%0d exp cnt=%0d/%0d",
               {b1_ov, b1_oc, b1_od}, b1_bc, b1_fc, exp_bc, exp_fc);
    end
  endtask

  task automatic test_hold();
    logic [112:0] exp_o;
    do_reset();
    drive(1'b1, 16'h0001, 96'hA1, 1'b0, 4'h0);
    tick();
    drive(1'b1, 16'h0002, 96'hA2, 1'b0, 4'h0);
    tick();
    exp_o = {1'b1, 16'h0001, 96'hA1};
    checks++;
    if ({h2_ov, h2_oc, h2_od} !== exp_o) begin
      failures++;
      $display("FAIL hold_fill got=%h exp=%h", {h2_ov, h2_oc, h2_od}, exp_o);
    end
    drive(1'b1, 16'h0003, 96'hA3, 1'b1, 4'h0);
    for (int n = 1; n <= 4; n++) begin
      tick();
      $display("hold: cycle=%0d out=%h", n, {h2_ov, h2_oc, h2_od});
      checks++;
      if ({h2_ov, h2_oc, h2_od} !== exp_o) begin
        failures++;
        $display("FAIL hold_frozen cycle=%0d got=%h exp=%h", n, {h2_ov, h2_oc, h2_od}, exp_o);
      end
    end
    checks++;
    if (h2_bc !== 16'd0) begin
      failures++;
      $display("FAIL hold_no_bubble got=%0d exp=0", h2_bc);
    end
    drive(1'b1, 16'h0003, 96'hA3, 1'b0, 4'h0);
    tick();
    exp_o = {1'b1, 16'h0002, 96'hA2};
    checks++;
    if ({h2_ov, h2_oc, h2_od} !== exp_o) begin
      failures++;
      $display("FAIL hold_release got=%h exp=%h", {h2_ov, h2_oc, h2_od}, exp_o);
    end
    tick();
    exp_o = {1'b1, 16'h0003, 96'hA3};
    checks++;
    if ({h2_ov, h2_oc, h2_od} !== exp_o) begin
      failures++;
      $display("FAIL hold_release2 got=%h exp=%h", {h2_ov, h2_oc, h2_od}, exp_o);
    end
    // flush of stage 1 while holding keeps its own data, drops valid/ctrl
    drive(1'b1, 16'h0004, 96'hA4, 1'b1, 4'h2);
    tick();
    exp_o = {1'b0, 16'h0, 96'hA3};
    $display("hold+flush: out=%h flush_cnt=%0d", {h2_ov, h2_oc, h2_od}, h2_fc);
    checks++;
    if ({h2_ov, h2_oc, h2_od} !== exp_o) begin
      failures++;
      $display("FAIL hold_flush got=%h exp=%h", {h2_ov, h2_oc, h2_od}, exp_o);
    end
    checks++;
    if (h2_fc !== (PERF ? 16'd1 : 16'd0)) begin
      failures++;
      $display("FAIL hold_flush_cnt got=%0d exp=%0d", h2_fc, PERF ? 1 : 0);
    end
    drive(1'b1, 16'h0004, 96'hA4, 1'b0, 4'h0);
    tick();
    exp_o = {1'b1, 16'h0003, 96'hA3};
    checks++;
    if ({h2_ov, h2_oc, h2_od} !== exp_o) begin
      failures++;
      $display("FAIL hold_flush_resume got=%h exp=%h", {h2_ov, h2_oc, h2_od}, exp_o);
    end
  endtask

  task automatic test_flush_stall();
    logic [112:0] exp_o [5];
    logic [31:0]  exp_c [5];
    logic [3:0]   fl [5];
    logic [95:0]  dat [5];
    logic         stl [5];
    exp_o = '{{1'b0, 16'h0, 96'hA1}, {1'b0, 16'h0, 96'hA2}, {1'b0, 16'h0, 96'hA2},
              {1'b0, 16'h0, 96'hA3}, {1'b1, 16'h0033, 96'hA3}};
    exp_c = '{{16'd1, 16'd1}, {16'd2, 16'd1}, {16'd2, 16'd2}, {16'd2, 16'd2}, {16'd2, 16'd2}};
    fl    = '{4'h2, 4'h2, 4'h1, 4'h0, 4'h0};
    dat   = '{96'hA2, 96'hA2, 96'hA3, 96'hA3, 96'hA3};
    stl   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    drive(1'b1, 16'h0011, 96'hA1, 1'b0, 4'h0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, (k < 2) ? 16'h0022 : 16'h0033, dat[k], stl[k], fl[k]);
      tick();
      $display("flush_stall: step=%0d out=%h bubble_cnt=%0d flush_cnt=%0d",
               k, {f2_ov, f2_oc, f2_od}, f2_bc, f2_fc);
      checks++;
      if ({f2_ov, f2_oc, f2_od} !== exp_o[k]) begin
        failures++;
        $display("FAIL flush_stall_out step=%0d got=%h exp=%h", k, {f2_ov, f2_oc, f2_od}, exp_o[k]);
      end
      checks++;
      if ({f2_bc, f2_fc} !== (PERF ? exp_c[k] : 32'h0)) begin
        failures++;
        $display("FAIL flush_stall_cnt step=%0d got=%h exp=%h", k, {f2_bc, f2_fc},
                 PERF ? exp_c[k] : 32'h0);
      end
    end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_bc;
    do_reset();
    drive(1'b1, 16'h0005, 96'h55, 1'b1, 4'h0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1 || k == 14 || k == 15 || k == 16 || k == 20) begin
        exp_bc = PERF ? ((k > 15) ? 4'd15 : 4'(k)) : 4'd0;
        $display("saturation: cycle=%0d bubble_cnt=%0d", k, b1_bc);
        checks++;
        if (b1_bc !== exp_bc) begin
          failures++;
          $display("FAIL sat_bubble cycle=%0d got=%0d exp=%0d", k, b1_bc, exp_bc);
        end
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({b1_bc, b1_fc, b1_ov} !== 9'h0) begin
      failures++;
      $display("FAIL sat_reset_clear got=%0d/%0d/%0b exp=0/0/0", b1_bc, b1_fc, b1_ov);
    end
    rst = 1'b0;
    drive(1'b0, 16'h0, 96'h0, 1'b0, 4'h0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 16'h0, 96'h0, 1'b0, 4'h0);
    repeat (2) tick();
    rst = 1'b0;
    test_reset();
    test_latency();
    test_bubble();
    test_hold();
    test_flush_stall();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
